fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 26 ++
 rtl/fetch_unit.sv | 110 +++++++++++
 tb/tb_fetch_unit.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: PC generator handshake, instruction memory port and decode port.
// master = fetch unit side, slave = PC generator / memory / decode side.
interface fetch_unit_if;
  logic [31:0] pc;
  logic        pc_advance;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;

  modport master (
    input  pc, flush, imem_gnt, imem_rvalid, imem_rdata, id_ready,
    output pc_advance, imem_req, imem_addr, id_valid, id_pc, id_instr
  );

  modport slave (
    output pc, flush, imem_gnt, imem_rvalid, imem_rdata, id_ready,
    input  pc_advance, imem_req, imem_addr, id_valid, id_pc, id_instr
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding memory requests feeding a DEPTH-entry
// circular buffer of {pc, instr} toward decode, with flush and drain of stale responses.
//   state | meaning
//   IDLE  | may issue a request
//   WAIT  | one request granted, awaiting rvalid
//   DRAIN | awaiting a response that will be discarded
module fetch_unit #(
  parameter int DEPTH = 2
) (
  input  logic         clock,
  input  logic         reset,
  fetch_unit_if.master bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] occ, occ_after_pop;
  logic [31:0]   tag;
  logic [31:0]   buf_pc    [DEPTH];
  logic [31:0]   buf_instr [DEPTH];
  logic          rst_q, hold, head_valid, pop, push, req, capture;
  logic          unused_pc_bits;

  assign unused_pc_bits = &{1'b0, bus.pc[1:0]};

  // Requests stay quiet in the reset cycle and the one after it.
  assign hold          = reset | rst_q;
  assign head_valid    = (occ != '0) && !reset;
  assign pop           = head_valid && bus.id_ready && !bus.flush;
  assign occ_after_pop = occ - CW'(pop);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    capture   = 1'b0;
    push      = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.flush && !hold && (occ_after_pop < DEPTH_C)) begin
          req = 1'b1;
          if (bus.imem_gnt) begin
            capture   = 1'b1;
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus.imem_rvalid) begin
          push      = !bus.flush;
          state_nxt = IDLE;
        end else if (bus.flush) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // The awaited response ends the drain even if another flush lands with it.
        if (bus.imem_rvalid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rst_q  <= 1'b1;
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
      tag    <= '0;
    end else begin
      rst_q <= 1'b0;
      if (capture) tag <= {bus.pc[31:2], 2'b00};
      if (bus.flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        occ    <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        occ <= occ + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      buf_pc[wr_ptr]    <= tag;
      buf_instr[wr_ptr] <= bus.imem_rdata;
    end
  end

  assign bus.imem_req   = req;
  assign bus.imem_addr  = {bus.pc[31:2], 2'b00};
  assign bus.pc_advance = capture;
  assign bus.id_valid   = head_valid;
  assign bus.id_pc      = head_valid ? buf_pc[rd_ptr]    : 32'h0;
  assign bus.id_instr   = head_valid ? buf_instr[rd_ptr] : 32'h0000_0013;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand-written corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_fetch_unit;
  localparam int DEPTH = 2;
  localparam logic [31:0] A   = 32'h0100_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  fetch_unit_if bus ();

  fetch_unit #(.DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit          rst;
    bit          fl;
    bit          gnt;
    bit          rv;
    logic [31:0] rdata;
    bit          rdy;
    bit          e_req;
    bit          e_adv;
    bit          e_valid;
    logic [31:0] e_addr;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  vec_t tbl [21];

  // Environment: PC generator and reference model state.
  logic [31:0] pc_q = A;
  bit          redirect_en = 1'b0;
  logic [63:0] mq [$];
  bit          m_out = 1'b0, m_disc = 1'b0, m_hold = 1'b0;
  logic [31:0] m_tag = '0;
  bit          e_req, e_adv, e_valid;
  logic [31:0] e_addr, e_pc, e_instr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input bit rst, input bit fl, input bit g, input bit rv,
                      input logic [31:0] rd, input bit rdy, input bit cmp);
    bit pop;
    @(negedge clock);
    reset           = rst;
    bus.flush       = fl;
    bus.imem_gnt    = g;
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rd;
    bus.id_ready    = rdy;
    bus.pc          = pc_q;
    #1;
    e_valid = !rst && (mq.size() > 0);
    e_pc    = e_valid ? mq[0][63:32] : 32'h0;
    e_instr = e_valid ? mq[0][31:0]  : NOP;
    pop     = e_valid && rdy;
    e_req   = !rst && !m_hold && !m_out && !fl && ((mq.size() - int'(pop)) < DEPTH);
    e_adv   = e_req && g;
    e_addr  = pc_q & 32'hFFFF_FFFC;
    if (cmp) begin
      chk("m_req",   bus.imem_req,   e_req);
      chk("m_adv",   bus.pc_advance, e_adv);
      chk("m_addr",  bus.imem_addr,  e_addr);
      chk("m_valid", bus.id_valid,   e_valid);
      chk("m_pc",    bus.id_pc,      e_pc);
      chk("m_instr", bus.id_instr,   e_instr);
    end
    if (rst) begin
      mq.delete();
      m_out = 0; m_disc = 0; m_tag = '0; m_hold = 1;
    end else begin
      m_hold = 0;
      if (fl) begin
        mq.delete();
        if (m_out && rv) begin m_out = 0; m_disc = 0; end
        else if (m_out) m_disc = 1;
      end else begin
        if (pop) void'(mq.pop_front());
        if (m_out && rv) begin
          if (!m_disc) mq.push_back({m_tag, rd});
          m_out = 0; m_disc = 0;
        end
      end
      if (e_adv) begin m_out = 1; m_tag = e_addr; end
    end
    if (rst)                      pc_q = A;
    else if (fl && redirect_en)   pc_q = $urandom;
    else if (bus.pc_advance)      pc_q = pc_q + 32'd4;
  endtask

  logic [31:0] last_g, gaddr0, gaddr1, dpc0, dpc1, dins0, dins1;
  int          grants, n_del, mem_lat;
  bit          rv_next, resumed, r, f, g, y, v;

  initial begin
    bus.flush = 0; bus.imem_gnt = 0; bus.imem_rvalid = 0; bus.imem_rdata = '0;
    bus.id_ready = 0; bus.pc = A;

    tbl[0]  = '{1,0,0,0,32'h0,0,         0,0,0, A,      32'h0, NOP};
    tbl[1]  = '{0,0,1,0,32'h0,0,         0,0,0, A,      32'h0, NOP};
    tbl[2]  = '{0,0,1,0,32'h0,1,         1,1,0, A,      32'h0, NOP};
    tbl[3]  = '{0,0,1,1,32'h00500093,1,  0,0,0, A+4,    32'h0, NOP};
    tbl[4]  = '{0,0,0,0,32'h0,1,         1,0,1, A+4,    A,     32'h00500093};
    tbl[5]  = '{0,0,0,0,32'h0,1,         1,0,0, A+4,    32'h0, NOP};
    tbl[6]  = '{0,0,0,0,32'h0,1,         1,0,0, A+4,    32'h0, NOP};
    tbl[7]  = '{0,0,1,0,32'h0,1,         1,1,0, A+4,    32'h0, NOP};
    tbl[8]  = '{0,1,0,0,32'h0,1,         0,0,0, A+8,    32'h0, NOP};
    tbl[9]  = '{0,0,0,0,32'h0,1,         0,0,0, A+8,    32'h0, NOP};
    tbl[10] = '{0,0,0,1,32'hDEADBEEF,1,  0,0,0, A+8,    32'h0, NOP};
    tbl[11] = '{0,0,0,0,32'h0,1,         1,0,0, A+8,    32'h0, NOP};
    tbl[12] = '{0,0,1,0,32'h0,0,         1,1,0, A+8,    32'h0, NOP};
    tbl[13] = '{0,0,0,1,32'h11111111,0,  0,0,0, A+12,   32'h0, NOP};
    tbl[14] = '{0,0,1,0,32'h0,0,         1,1,1, A+12,   A+8,   32'h11111111};
    tbl[15] = '{0,0,0,1,32'h22222222,0,  0,0,1, A+16,   A+8,   32'h11111111};
    tbl[16] = '{0,0,1,0,32'h0,0,         0,0,1, A+16,   A+8,   32'h11111111};
    tbl[17] = '{0,0,1,0,32'h0,1,         1,1,1, A+16,   A+8,   32'h11111111};
    tbl[18] = '{1,0,0,0,32'h0,0,         0,0,0, A+20,   32'h0, NOP};
    tbl[19] = '{0,0,1,1,32'h33333333,0,  0,0,0, A,      32'h0, NOP};
    tbl[20] = '{0,0,0,0,32'h0,1,         1,0,0, A,      32'h0, NOP};

    for (int i = 0; i < 21; i++) begin
      step(tbl[i].rst, tbl[i].fl, tbl[i].gnt, tbl[i].rv, tbl[i].rdata, tbl[i].rdy, 0);
      chk($sformatf("row%0d_req", i),   bus.imem_req,   tbl[i].e_req);
      chk($sformatf("row%0d_adv", i),   bus.pc_advance, tbl[i].e_adv);
      chk($sformatf("row%0d_addr", i),  bus.imem_addr,  tbl[i].e_addr);
      chk($sformatf("row%0d_valid", i), bus.id_valid,   tbl[i].e_valid);
      chk($sformatf("row%0d_pc", i),    bus.id_pc,      tbl[i].e_pc);
      chk($sformatf("row%0d_instr", i), bus.id_instr,   tbl[i].e_instr);
    end

    // Backpressure: buffer fills after exactly DEPTH grants, then drains in order.
    step(1, 0, 0, 0, 32'h0, 0, 1);
    step(0, 0, 1, 0, 32'h0, 0, 1);
    grants = 0; rv_next = 0; last_g = '0; gaddr0 = '0; gaddr1 = '0;
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1, rv_next, last_g ^ 32'h5A5A_0000, 0, 1);
      rv_next = bus.pc_advance;
      if (bus.pc_advance) begin
        if (grants == 0) gaddr0 = bus.imem_addr;
        if (grants == 1) gaddr1 = bus.imem_addr;
        last_g = bus.imem_addr;
        grants++;
      end
    end
    chk("full_grants", grants, 2);
    chk("full_gaddr0", gaddr0, A);
    chk("full_gaddr1", gaddr1, A + 4);
    chk("full_req_low", bus.imem_req, 1'b0);
    n_del = 0; resumed = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 1, rv_next, last_g ^ 32'h5A5A_0000, 1, 1);
      rv_next = bus.pc_advance;
      if (bus.pc_advance) begin
        if (bus.imem_addr == A + 8) resumed = 1;
        last_g = bus.imem_addr;
      end
      if (bus.id_valid && n_del < 2) begin
        if (n_del == 0) begin dpc0 = bus.id_pc; dins0 = bus.id_instr; end
        else            begin dpc1 = bus.id_pc; dins1 = bus.id_instr; end
        n_del++;
      end
    end
    chk("drain_count", n_del, 2);
    chk("drain_pc0", dpc0, A);
    chk("drain_instr0", dins0, A ^ 32'h5A5A_0000);
    chk("drain_pc1", dpc1, A + 4);
    chk("drain_instr1", dins1, (A + 4) ^ 32'h5A5A_0000);
    chk("drain_resumed", resumed, 1'b1);

    // Flush coincident with rvalid while one entry is buffered.
    step(1, 0, 0, 0, 32'h0, 0, 1);
    step(0, 0, 0, 0, 32'h0, 0, 1);
    step(0, 0, 1, 0, 32'h0, 0, 1);
    step(0, 0, 0, 1, 32'h0BAD_0001, 0, 1);
    step(0, 0, 1, 0, 32'h0, 0, 1);
    chk("fr_one_entry", bus.id_valid, 1'b1);
    step(0, 1, 0, 1, 32'hCAFE_F00D, 1, 1);
    step(0, 0, 0, 0, 32'h0, 1, 1);
    chk("fr_valid_low", bus.id_valid, 1'b0);
    chk("fr_idle_req", bus.imem_req, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 32'h0, 1, 1);
      chk("fr_never_shown", bus.id_valid, 1'b0);
    end

    // Randomized traffic against the reference model.
    redirect_en = 1;
    mem_lat = -1;
    step(1, 0, 0, 0, 32'h0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 99) == 0);
      f = ($urandom_range(0, 15) == 0);
      g = ($urandom_range(0, 9) < 7);
      y = ($urandom_range(0, 9) < 6);
      v = (mem_lat == 0);
      step(r, f, g, v, $urandom, y, 1);
      if (v) mem_lat = -1;
      else if (mem_lat > 0) mem_lat--;
      if (bus.imem_req && g) mem_lat = $urandom_range(0, 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
